// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of the data-RAM port; one request in flight.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned LH/LHU/SH/LW/SW into errors.
module lsu_mem_ctrl #(
  parameter logic [31:0] DMEM_BASE = 32'h00010000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ReqValid_i,
  output logic        ReqReady_o,
  input  logic        ReqWrite_i,
  input  logic [2:0]  ReqFunct3_i,
  input  logic [31:0] ReqAddr_i,
  input  logic [31:0] ReqWData_i,
  output logic        RspValid_o,
  output logic [31:0] RspData_o,
  output logic        RspErr_o,
  output logic [31:0] DMemRAddr_o,
  input  logic [63:0] DMemRData_i,
  output logic [31:0] DMemWAddr_o,
  output logic [63:0] DMemWData_o,
  output logic [4:0]  DMemWMask_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW,
    S_STORE,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, hi_q, hi_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  f3_q;
  logic        write_q, err_q, err_d;

  // Request decode, evaluated on the raw inputs in the accept cycle
  logic [1:0] req_off;
  logic       req_illegal, req_cross;

  assign req_off = ReqAddr_i[1:0];

  always_comb begin
    if (ReqWrite_i)
      req_illegal = ReqFunct3_i[2] | (ReqFunct3_i[1:0] == 2'b11);
    else
      req_illegal = (ReqFunct3_i == 3'b011) | (ReqFunct3_i[2:1] == 2'b11);
  end

  assign req_cross = ReqWrite_i &
    (((ReqFunct3_i[1:0] == 2'b10) & (req_off != 2'd0)) |
     ((ReqFunct3_i[1:0] == 2'b01) & (req_off == 2'd3)));

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_misal;
  assign req_misal =
    ((ReqFunct3_i[1:0] == 2'b01) & ReqAddr_i[0]) |
    ((ReqFunct3_i[1:0] == 2'b10) & (req_off != 2'd0));
`endif

  // Datapath on the latched request
  logic [1:0]  off_q;
  logic [31:0] aligned;
  logic [4:0]  sh8;
  logic [3:0]  smask, lo_mask, hi_bmask;
  logic [2:0]  size3, nsum, nspill, rbytes;
  logic [5:0]  rsh;
  logic [31:0] lo_data, spill, hi_merge, win32, ld_ext;
  logic        cross_q;

  assign off_q   = addr_q[1:0];
  assign aligned = {addr_q[31:2], 2'b00};
  assign sh8     = {off_q, 3'b000};

  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   begin smask = 4'b0001; size3 = 3'd1; end
      2'b01:   begin smask = 4'b0011; size3 = 3'd2; end
      default: begin smask = 4'b1111; size3 = 3'd4; end
    endcase
  end

  assign cross_q = write_q &
    (((f3_q[1:0] == 2'b10) & (off_q != 2'd0)) |
     ((f3_q[1:0] == 2'b01) & (off_q == 2'd3)));

  assign lo_data = wdata_q << sh8;
  assign lo_mask = smask << off_q;

  // Bytes that spill past the word boundary land in the low bytes of word+1
  assign nsum     = {1'b0, off_q} + size3;
  assign nspill   = nsum - 3'd4;
  assign hi_bmask = (4'b0001 << nspill) - 4'd1;
  assign rbytes   = 3'd4 - {1'b0, off_q};
  assign rsh      = {rbytes, 3'b000};
  assign spill    = wdata_q >> rsh;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hi_merge[8*i +: 8] = hi_bmask[i] ? spill[8*i +: 8]
                                       : DMemRData_i[32+8*i +: 8];
    end
  end

  assign win32 = 32'(DMemRData_i >> sh8);

  always_comb begin
    unique case (f3_q)
      3'b000:  ld_ext = {{24{win32[7]}}, win32[7:0]};
      3'b001:  ld_ext = {{16{win32[15]}}, win32[15:0]};
      3'b100:  ld_ext = {24'd0, win32[7:0]};
      3'b101:  ld_ext = {16'd0, win32[15:0]};
      default: ld_ext = win32;
    endcase
  end

  // Next-state and port logic
  logic        ready, rsp_valid;
  logic [31:0] raddr, waddr;
  logic [63:0] wdata;
  logic [4:0]  wmask;

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    hi_d      = hi_q;
    ready     = 1'b0;
    rsp_valid = 1'b0;
    raddr     = 32'd0;
    waddr     = 32'd0;
    wdata     = 64'd0;
    wmask     = 5'd0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (ReqValid_i) begin
          err_d = 1'b0;
          if (req_illegal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (req_misal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`endif
          else if (!ReqWrite_i) state_d = S_LOAD;
          else if (req_cross)   state_d = S_RMW;
          else                  state_d = S_STORE;
        end
      end
      S_LOAD: begin
        raddr   = aligned;
        rdata_d = ld_ext;
        state_d = S_RESP;
      end
      S_RMW: begin
        raddr   = aligned;
        hi_d    = hi_merge;
        state_d = S_STORE;
      end
      S_STORE: begin
        waddr   = aligned;
        wdata   = {cross_q ? hi_q : 32'd0, lo_data};
        wmask   = {cross_q, lo_mask};
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      hi_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
      if (ready && ReqValid_i) begin
        addr_q  <= ReqAddr_i;
        wdata_q <= ReqWData_i;
        f3_q    <= ReqFunct3_i;
        write_q <= ReqWrite_i;
      end
    end
  end

  // Reset masks every strobe so an aborted STORE never reaches memory
  assign ReqReady_o  = ready & ~rst_i;
  assign RspValid_o  = rsp_valid & ~rst_i;
  assign RspErr_o    = rsp_valid & ~rst_i & err_q;
  assign RspData_o   = rdata_q;
  assign DMemRAddr_o = rst_i ? 32'd0 : raddr;
  assign DMemWAddr_o = rst_i ? 32'd0 : waddr;
  assign DMemWData_o = rst_i ? 64'd0 : wdata;
  assign DMemWMask_o = rst_i ? 5'd0 : wmask;

  always_ff @(posedge clk_i) begin
    if (!rst_i && ReqValid_i && ReqReady_o)
      assert (ReqAddr_i >= DMEM_BASE);
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests, queued expectations.
// Response and write monitors check the DUT independently of the driver.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ReqValid_i, ReqWrite_i;
  logic        ReqReady_o;
  logic [2:0]  ReqFunct3_i;
  logic [31:0] ReqAddr_i, ReqWData_i;
  logic        RspValid_o, RspErr_o;
  logic [31:0] RspData_o;
  logic [31:0] DMemRAddr_o, DMemWAddr_o;
  logic [63:0] DMemRData_i, DMemWData_o;
  logic [4:0]  DMemWMask_o;

  lsu_mem_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ReqValid_i  (ReqValid_i),
    .ReqReady_o  (ReqReady_o),
    .ReqWrite_i  (ReqWrite_i),
    .ReqFunct3_i (ReqFunct3_i),
    .ReqAddr_i   (ReqAddr_i),
    .ReqWData_i  (ReqWData_i),
    .RspValid_o  (RspValid_o),
    .RspData_o   (RspData_o),
    .RspErr_o    (RspErr_o),
    .DMemRAddr_o (DMemRAddr_o),
    .DMemRData_i (DMemRData_i),
    .DMemWAddr_o (DMemWAddr_o),
    .DMemWData_o (DMemWData_o),
    .DMemWMask_o (DMemWMask_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [16];
  logic [3:0]  widx;
  assign widx = DMemRAddr_o[5:2];
  assign DMemRData_i = {mem[widx + 4'd1], mem[widx]};

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          chk;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [4:0]  mask;
    int          cyc;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (RspValid_o) begin
      if (rq.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = rq.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp_err", 64'(RspErr_o), 64'(e.err));
        if (e.chk) chk("rsp_data", 64'(RspData_o), 64'(e.data));
      end
    end
    if (DMemWMask_o != 5'd0) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 64'(DMemWMask_o), 64'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(w.cyc));
        chk("wr_addr", 64'(DMemWAddr_o), 64'(w.addr));
        chk("wr_mask", 64'(DMemWMask_o), 64'(w.mask));
        chk("wr_data", DMemWData_o, w.data);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ReqReady_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ReqReady_o) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  // lat < 0 means no response expected; wlat < 0 means no write expected
  task automatic issue(input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int lat, input logic err,
                       input logic [31:0] data, input bit dchk,
                       input int wlat, input logic [31:0] waddr,
                       input logic [63:0] wdat, input logic [4:0] wmask);
    rsp_t r;
    wr_t  w;
    wait_ready();
    ReqValid_i  = 1'b1;
    ReqWrite_i  = wr;
    ReqFunct3_i = f3;
    ReqAddr_i   = addr;
    ReqWData_i  = wd;
    if (lat >= 0) begin
      r.err = err; r.data = data; r.chk = dchk; r.cyc = cyc + lat;
      rq.push_back(r);
    end
    if (wlat >= 0) begin
      w.addr = waddr; w.data = wdat; w.mask = wmask; w.cyc = cyc + wlat;
      wq.push_back(w);
    end
    @(negedge clk);
    ReqValid_i  = 1'b0;
    ReqWrite_i  = 1'bx;
    ReqFunct3_i = 3'bx;
    ReqAddr_i   = 32'hx;
    ReqWData_i  = 32'hx;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h80FF1234;
    mem[1] = 32'h44332211;
    mem[2] = 32'h88776655;
    rst_i = 1'b1;
    ReqValid_i = 1'b0;
    ReqWrite_i = 1'b0;
    ReqFunct3_i = 3'b0;
    ReqAddr_i = 32'h00010000;
    ReqWData_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ReqReady_o), 64'd0);
    chk("rst_rspvalid", 64'(RspValid_o), 64'd0);
    chk("rst_rsperr", 64'(RspErr_o), 64'd0);
    chk("rst_rspdata", 64'(RspData_o), 64'd0);
    chk("rst_wmask", 64'(DMemWMask_o), 64'd0);
    chk("rst_raddr", 64'(DMemRAddr_o), 64'd0);
    chk("rst_waddr", 64'(DMemWAddr_o), 64'd0);
    rst_i = 1'b0;

    issue(0, 3'b000, 32'h00010003, 0, 2, 0, 32'hFFFFFF80, 1, -1, 0, 0, 0);
    issue(0, 3'b100, 32'h00010003, 0, 2, 0, 32'h00000080, 1, -1, 0, 0, 0);
    issue(0, 3'b001, 32'h00010002, 0, 2, 0, 32'hFFFF80FF, 1, -1, 0, 0, 0);
    issue(0, 3'b101, 32'h00010000, 0, 2, 0, 32'h00001234, 1, -1, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 3'b010, 32'h00010005, 0, 1, 1, 32'h00001234, 1, -1, 0, 0, 0);
`else
    issue(0, 3'b010, 32'h00010005, 0, 2, 0, 32'h55443322, 1, -1, 0, 0, 0);
`endif
    issue(1, 3'b010, 32'h00010000, 32'hDEADBEEF, 2, 0, 0, 0,
          1, 32'h00010000, 64'h00000000_DEADBEEF, 5'b01111);
    issue(1, 3'b000, 32'h00010001, 32'h1234565A, 2, 0, 0, 0,
          1, 32'h00010000, 64'h00000000_34565A00, 5'b00010);
    issue(1, 3'b001, 32'h00010002, 32'hFFFF7788, 2, 0, 0, 0,
          1, 32'h00010000, 64'h00000000_77880000, 5'b01100);
    wait_ready();
    mem[2] = 32'h11223344;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1, 3'b001, 32'h00010007, 32'h0000BEEF, 1, 1, 0, 0, -1, 0, 0, 0);
    issue(1, 3'b010, 32'h00010006, 32'hAABBCCDD, 1, 1, 0, 0, -1, 0, 0, 0);
`else
    issue(1, 3'b001, 32'h00010007, 32'h0000BEEF, 3, 0, 0, 0,
          2, 32'h00010004, 64'h112233BE_EF000000, 5'b11000);
    issue(1, 3'b010, 32'h00010006, 32'hAABBCCDD, 3, 0, 0, 0,
          2, 32'h00010004, 64'h1122AABB_CCDD0000, 5'b11100);
`endif
    issue(0, 3'b011, 32'h00010000, 0, 1, 1, 0, 0, -1, 0, 0, 0);
    issue(1, 3'b100, 32'h00010000, 32'h12345678, 1, 1, 0, 0, -1, 0, 0, 0);
    issue(0, 3'b110, 32'h00010004, 0, 1, 1, 0, 0, -1, 0, 0, 0);

    // Crossing store aborted by reset one cycle after accept
    issue(1, 3'b010, 32'h00010006, 32'hCAFEF00D, -1, 0, 0, 0, -1, 0, 0, 0);
    rst_i = 1'b1;
    #1;
    chk("abort_ready", 64'(ReqReady_o), 64'd0);
    chk("abort_wmask", 64'(DMemWMask_o), 64'd0);
    chk("abort_rspvalid", 64'(RspValid_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(ReqReady_o), 64'd1);
    repeat (4) @(negedge clk);

    issue(0, 3'b010, 32'h00010004, 0, 2, 0, 32'h44332211, 1, -1, 0, 0, 0);

    begin
      int n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (2) @(negedge clk);
    chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
    chk("wr_queue_drained", 64'(wq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
